aes_engine_stream_if: RTL and testbench

//   Engine-side responder to the AES control FSM and its streamers.
//   - Sinks 32-bit plaintext words from the source stream and packs them into 128-bit blocks.
//   - Hands each block to the AES core and captures the 128-bit ciphertext.
//   - Serialises the ciphertext onto the sink stream as 32-bit words.
//   - Obeys the FSM's clear/start/enable controls and returns busy/done flags.
//

---
 rtl/aes_engine_stream_if_if.sv | 39 +++
 rtl/aes_engine_stream_if.sv | 127 ++++++++++++
 tb/tb_aes_engine_stream_if.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_engine_stream_if_if.sv
// rtl/aes_engine_stream_if_if.sv - control, stream and core signals between the AES ctrl side and the engine
interface aes_engine_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WIDTH = 128,
  parameter int CNT_WIDTH   = 8
);
  logic                   clear;
  logic                   start;
  logic                   enable;
  logic [CNT_WIDTH-1:0]   nb_blocks;
  logic [DATA_WIDTH-1:0]  in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [BLOCK_WIDTH-1:0] core_block;
  logic                   core_valid;
  logic                   core_ready;
  logic [BLOCK_WIDTH-1:0] core_result;
  logic                   core_result_valid;
  logic [DATA_WIDTH-1:0]  out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   busy;
  logic                   done;
  logic [CNT_WIDTH-1:0]   blk_cnt;

  modport master (
    output clear, start, enable, nb_blocks, in_data, in_valid,
           core_ready, core_result, core_result_valid, out_ready,
    input  in_ready, core_block, core_valid, out_data, out_valid,
           busy, done, blk_cnt
  );

  modport slave (
    input  clear, start, enable, nb_blocks, in_data, in_valid,
           core_ready, core_result, core_result_valid, out_ready,
    output in_ready, core_block, core_valid, out_data, out_valid,
           busy, done, blk_cnt
  );
endinterface

// File: rtl/aes_engine_stream_if.sv
// rtl/aes_engine_stream_if.sv - packs input words into AES blocks, issues them to the core, drains results
module aes_engine_stream_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WIDTH = 128,
  parameter int CNT_WIDTH   = 8
) (
  input logic        clk,
  input logic        reset,
  aes_engine_if.slave bus
);
  localparam int WORDS = BLOCK_WIDTH / DATA_WIDTH;
  localparam int WIDX  = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, DRAIN, DONE} state_t;

  state_t                 state, next_state;
  logic [WIDX-1:0]        word_cnt;
  logic [CNT_WIDTH-1:0]   nb_q;
  logic [CNT_WIDTH-1:0]   blk_cnt_q;
  logic [BLOCK_WIDTH-1:0] block_q;
  logic [BLOCK_WIDTH-1:0] result_q;

  logic in_ready_c, core_valid_c, out_valid_c, done_c;
  logic latch_start, load_word, capture, drain_word;
  logic word_last;

  assign word_last = (word_cnt == WIDX'(WORDS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state   = state;
    in_ready_c   = 1'b0;
    core_valid_c = 1'b0;
    out_valid_c  = 1'b0;
    done_c       = 1'b0;
    latch_start  = 1'b0;
    load_word    = 1'b0;
    capture      = 1'b0;
    drain_word   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          latch_start = 1'b1;
          next_state  = (bus.nb_blocks == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        in_ready_c = bus.enable;
        if (bus.in_valid && bus.enable) begin
          load_word = 1'b1;
          if (word_last) next_state = ISSUE;
        end
      end
      ISSUE: begin
        core_valid_c = 1'b1;
        if (bus.core_ready && bus.enable) next_state = WAIT;
      end
      WAIT: begin
        if (bus.core_result_valid) begin
          capture    = 1'b1;
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        out_valid_c = 1'b1;
        if (bus.out_ready && bus.enable) begin
          drain_word = 1'b1;
          if (word_last) begin
            if (({1'b0, blk_cnt_q} + 1'b1) < {1'b0, nb_q}) next_state = LOAD;
            else                                           next_state = DONE;
          end
        end
      end
      DONE: begin
        done_c     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    // clear wins over everything, including a start seen in the same cycle
    if (bus.clear) next_state = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_cnt  <= '0;
      nb_q      <= '0;
      blk_cnt_q <= '0;
      block_q   <= '0;
      result_q  <= '0;
    end else if (bus.clear) begin
      word_cnt  <= '0;
      nb_q      <= '0;
      blk_cnt_q <= '0;
      block_q   <= '0;
      result_q  <= '0;
    end else begin
      if (latch_start) begin
        nb_q      <= bus.nb_blocks;
        blk_cnt_q <= '0;
        word_cnt  <= '0;
      end
      if (load_word) begin
        block_q[word_cnt*DATA_WIDTH +: DATA_WIDTH] <= bus.in_data;
        word_cnt <= word_last ? '0 : word_cnt + 1'b1;
      end
      if (capture) result_q <= bus.core_result;
      if (drain_word) begin
        word_cnt <= word_last ? '0 : word_cnt + 1'b1;
        if (word_last && (blk_cnt_q != nb_q)) blk_cnt_q <= blk_cnt_q + 1'b1;
      end
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.core_valid = core_valid_c;
  assign bus.core_block = block_q;
  assign bus.out_valid  = out_valid_c;
  assign bus.out_data   = result_q[word_cnt*DATA_WIDTH +: DATA_WIDTH];
  assign bus.busy       = (state != IDLE);
  assign bus.done       = done_c;
  assign bus.blk_cnt    = blk_cnt_q;
endmodule

// File: tb/tb_aes_engine_stream_if.sv
// tb/tb_aes_engine_stream_if.sv - directed bench for the AES engine stream responder
module tb_aes_engine_stream_if;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  aes_engine_if bus_if ();
  aes_engine_stream_if dut (.clk(clk), .reset(reset), .bus(bus_if));

  int vectors = 0;
  int errors  = 0;

  logic [31:0]  src[$];
  logic [31:0]  got[$];
  logic [127:0] last_blk;
  logic         in_lat, out_lat;
  bit           abort, job_done;
  int           stab_err, held;
  int           done_cnt = 0, in_fire_cnt = 0, core_fire_cnt = 0, out_fire_cnt = 0;

  always @(negedge clk) begin
    if (bus_if.done) done_cnt++;
    if (bus_if.in_valid && bus_if.in_ready && bus_if.enable) in_fire_cnt++;
    if (bus_if.core_valid && bus_if.core_ready && bus_if.enable) core_fire_cnt++;
    if (bus_if.out_valid && bus_if.out_ready && bus_if.enable) out_fire_cnt++;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic producer(input int n, input int pct);
    int i = 0;
    logic acc;
    while (i < n && !abort) begin
      if (!bus_if.in_valid && $urandom_range(99) < pct) begin
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = src[i];
      end
      @(negedge clk);
      acc = bus_if.in_valid && bus_if.in_ready && bus_if.enable;
      @(posedge clk); #1;
      if (acc) begin
        i++;
        bus_if.in_valid = 1'b0;
        in_lat = bus_if.core_valid;
      end
    end
    bus_if.in_valid = 1'b0;
  endtask

  task automatic core_task(input int nblk, input logic [127:0] mask, input bit respond);
    int b = 0;
    logic acc;
    logic [127:0] blk;
    while (b < nblk && !abort) begin
      bus_if.core_ready = 1'b1;
      @(negedge clk);
      acc = bus_if.core_valid && bus_if.core_ready && bus_if.enable;
      blk = bus_if.core_block;
      @(posedge clk); #1;
      if (acc) begin
        b++;
        last_blk = blk;
        if (respond) begin
          bus_if.core_result       = blk ^ mask;
          bus_if.core_result_valid = 1'b1;
          @(posedge clk); #1;
          bus_if.core_result_valid = 1'b0;
          out_lat = bus_if.out_valid;
        end
      end
    end
    bus_if.core_ready = 1'b0;
  endtask

  task automatic consumer(input int n, input int pct, input int hold);
    int k = 0;
    logic acc;
    logic pv = 1'b0;
    logic [31:0] pd = '0;
    while (k < n && !abort) begin
      bus_if.out_ready = ($urandom_range(99) < pct) && (hold == 0);
      @(negedge clk);
      if (pv && (!bus_if.out_valid || bus_if.out_data !== pd)) stab_err++;
      acc = bus_if.out_valid && bus_if.out_ready && bus_if.enable;
      if (bus_if.out_valid && !acc && hold > 0) begin
        hold--;
        held++;
      end
      if (acc) begin
        got.push_back(bus_if.out_data);
        k++;
      end
      pv = bus_if.out_valid && !acc;
      pd = bus_if.out_data;
      @(posedge clk); #1;
    end
    bus_if.out_ready = 1'b0;
  endtask

  task automatic en_ctrl(input int base);
    int c = 0;
    while ((in_fire_cnt - base) < 2 && c < 200 && !abort) begin
      @(posedge clk); #1;
      c++;
    end
    bus_if.enable = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus_if.enable = 1'b1;
  endtask

  task automatic run_job(input int nb, input int pct_in, input int pct_out, input logic [127:0] mask,
                         input int hold, input bit respond, input int n_out, input bit en_stall);
    int base;
    got.delete();
    abort = 0; job_done = 0; stab_err = 0; held = 0;
    @(posedge clk); #1;
    bus_if.nb_blocks = 8'(nb);
    bus_if.start = 1'b1;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    base = in_fire_cnt;
    fork
      begin
        fork
          producer(nb * 4, pct_in);
          core_task(nb, mask, respond);
          consumer(n_out, pct_out, hold);
          if (en_stall) en_ctrl(base);
        join
        job_done = 1;
      end
      begin
        int c = 0;
        while (!job_done && c < 4000) begin
          @(posedge clk);
          c++;
        end
        if (!job_done) abort = 1;
      end
    join
    check("job_timeout", 128'(abort), 128'd0);
  endtask

  task automatic check_words(input string tag, input int n, input logic [127:0] mask);
    check($sformatf("%s_count", tag), 128'(got.size()), 128'(n));
    for (int j = 0; j < n && j < got.size(); j++)
      check($sformatf("%s_word%0d", tag, j), 128'(got[j]), 128'(src[j] ^ mask[32*(j%4) +: 32]));
  endtask

  task automatic check_tail(input string tag, input int d0, input int blocks);
    repeat (3) @(posedge clk);
    #1;
    check($sformatf("%s_done_pulses", tag), 128'(done_cnt - d0), 128'd1);
    check($sformatf("%s_blk_cnt", tag), 128'(bus_if.blk_cnt), 128'(blocks));
    check($sformatf("%s_busy", tag), 128'(bus_if.busy), 128'd0);
  endtask

  initial begin
    int d0, f0;
    logic [127:0] mask;
    bus_if.clear = 0; bus_if.start = 0; bus_if.enable = 1; bus_if.nb_blocks = '0;
    bus_if.in_data = '0; bus_if.in_valid = 0; bus_if.core_ready = 0;
    bus_if.core_result = '0; bus_if.core_result_valid = 0; bus_if.out_ready = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 128'(bus_if.busy), 128'd0);
    check("rst_done", 128'(bus_if.done), 128'd0);
    check("rst_in_ready", 128'(bus_if.in_ready), 128'd0);
    check("rst_core_valid", 128'(bus_if.core_valid), 128'd0);
    check("rst_out_valid", 128'(bus_if.out_valid), 128'd0);
    check("rst_blk_cnt", 128'(bus_if.blk_cnt), 128'd0);
    check("rst_core_block", bus_if.core_block, 128'd0);
    check("rst_out_data", 128'(bus_if.out_data), 128'd0);
    reset = 1'b0;

    // single block, loopback core
    src = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    d0 = done_cnt;
    run_job(1, 100, 100, 128'd0, 0, 1, 4, 0);
    check("t1_core_block", last_blk, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
    check("t1_in_to_core_lat", 128'(in_lat), 128'd1);
    check("t1_res_to_out_lat", 128'(out_lat), 128'd1);
    check_words("t1", 4, 128'd0);
    check_tail("t1", d0, 1);

    // three blocks with random backpressure on both streams
    src.delete();
    for (int j = 0; j < 12; j++) src.push_back(32'h1000_0000 + 32'(j) * 32'h0101_0101);
    mask = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
    d0 = done_cnt;
    run_job(3, 50, 50, mask, 0, 1, 12, 0);
    check_words("t2", 12, mask);
    check("t2_stable", 128'(stab_err), 128'd0);
    check_tail("t2", d0, 3);

    // zero-block job: straight to done, no handshakes
    f0 = in_fire_cnt + core_fire_cnt + out_fire_cnt;
    d0 = done_cnt;
    @(posedge clk); #1;
    bus_if.nb_blocks = 8'd0;
    bus_if.start = 1'b1;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    check("t3_done_hi", 128'(bus_if.done), 128'd1);
    check("t3_blk_cnt_zeroed", 128'(bus_if.blk_cnt), 128'd0);
    @(posedge clk); #1;
    check("t3_done_lo", 128'(bus_if.done), 128'd0);
    check("t3_busy", 128'(bus_if.busy), 128'd0);
    check("t3_done_pulses", 128'(done_cnt - d0), 128'd1);
    check("t3_no_handshake", 128'(in_fire_cnt + core_fire_cnt + out_fire_cnt), 128'(f0));

    // enable dropped mid-block, sink stalled in drain
    src = '{32'hDEAD0001, 32'hBEEF0002, 32'hCAFE0003, 32'hF00D0004};
    mask = 128'h11111111_22222222_44444444_88888888;
    d0 = done_cnt;
    run_job(1, 100, 100, mask, 5, 1, 4, 1);
    check_words("t4", 4, mask);
    check("t4_stable", 128'(stab_err), 128'd0);
    check("t4_held_cycles", 128'(held), 128'd5);
    check_tail("t4", d0, 1);

    // clear while waiting on the core, then a stray result
    src = '{32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404};
    run_job(1, 100, 100, 128'd0, 0, 0, 0, 0);
    check("t5_busy_in_wait", 128'(bus_if.busy), 128'd1);
    bus_if.clear = 1'b1;
    @(posedge clk); #1;
    bus_if.clear = 1'b0;
    check("t5_busy_after_clear", 128'(bus_if.busy), 128'd0);
    check("t5_block_cleared", bus_if.core_block, 128'd0);
    bus_if.core_result = {4{32'hBAD0BAD0}};
    bus_if.core_result_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.core_result_valid = 1'b0;
    check("t5_stray_out_valid", 128'(bus_if.out_valid), 128'd0);
    check("t5_stray_busy", 128'(bus_if.busy), 128'd0);
    src = '{32'h89ABCDEF, 32'h01234567, 32'h76543210, 32'hFEDCBA98};
    mask = 128'h0F0F0F0F_F0F0F0F0_00FF00FF_FF00FF00;
    d0 = done_cnt;
    run_job(1, 100, 100, mask, 0, 1, 4, 0);
    check_words("t5", 4, mask);
    check_tail("t5", d0, 1);

    // asynchronous reset while draining
    src = '{32'h55550000, 32'h55551111, 32'h55552222, 32'h55553333};
    run_job(1, 100, 100, 128'd0, 0, 1, 0, 0);
    @(negedge clk);
    check("t6_in_drain", 128'(bus_if.out_valid), 128'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_out_valid", 128'(bus_if.out_valid), 128'd0);
    check("t6_rst_busy", 128'(bus_if.busy), 128'd0);
    check("t6_rst_out_data", 128'(bus_if.out_data), 128'd0);
    check("t6_rst_core_block", bus_if.core_block, 128'd0);
    check("t6_rst_blk_cnt", 128'(bus_if.blk_cnt), 128'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #1;
    check("t6_idle_busy", 128'(bus_if.busy), 128'd0);
    check("t6_idle_in_ready", 128'(bus_if.in_ready), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
